// File: rtl/uart_tx.sv
// uart_tx: memory-mapped UART transmitter with an 8-bit TX FIFO,
// a programmable baud divisor and an 8N1 serial frame engine.
module uart_tx #(
   parameter int DEFAULT_DIV = 16,
   parameter int FIFO_DEPTH  = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        sel,
   input  logic        we,
   input  logic [2:0]  memsize,
   input  logic [31:0] a,
   input  logic [31:0] wd,
   output logic [31:0] rd,
   output logic        tx
);

   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

   state_t        r_state, w_state_nxt;
   logic [7:0]    r_mem [FIFO_DEPTH];
   logic [AW-1:0] r_wptr, r_rptr;
   logic [AW:0]   r_count;
   logic          r_ovf;
   logic [15:0]   r_div;
   logic [15:0]   r_cnt, w_cnt_nxt;
   logic [7:0]    r_shift, w_shift_nxt;
   logic [2:0]    r_idx, w_idx_nxt;
   logic          r_tx, w_tx_nxt;
   logic          w_pop, w_push, w_push_ok, w_full, w_empty;
   logic          w_wr_stat, w_wr_div, w_bit_end;
   logic [15:0]   w_div_m1;
   logic [3:0]    w_cnt_sat;
   logic          w_unused;

   // memsize, unused address bits and upper store data are don't-cares
   assign w_unused  = ^{memsize, a[31:4], a[1:0], wd[31:16]};

   assign w_full    = (r_count == (AW+1)'(FIFO_DEPTH));
   assign w_empty   = (r_count == '0);
   assign w_push    = sel & we & (a[3:2] == 2'd0);
   assign w_wr_stat = sel & we & (a[3:2] == 2'd1);
   assign w_wr_div  = sel & we & (a[3:2] == 2'd2);
   // a full FIFO still accepts a push when the FSM pops on the same edge
   assign w_push_ok = w_push & (~w_full | w_pop);
   assign w_bit_end = (r_cnt == 16'd0);
   assign w_div_m1  = r_div - 16'd1;
   assign tx        = r_tx;

   // saturate the FIFO count into the 4-bit STATUS field
   always_comb begin
      w_cnt_sat = 4'(r_count);
      if (r_count > 15) w_cnt_sat = 4'hF;
   end

   // register read mux, purely combinational from address and state
   always_comb begin
      rd = '0;
      case (a[3:2])
         2'd1:    rd[7:0]  = {w_cnt_sat, r_ovf, (r_state != S_IDLE), w_empty, w_full};
         2'd2:    rd[15:0] = r_div;
         default: rd = '0;
      endcase
   end

   // frame sequencer: next state, bit timer, shifter and line level
   always_comb begin
      w_state_nxt = r_state;
      w_pop       = 1'b0;
      w_cnt_nxt   = r_cnt;
      w_shift_nxt = r_shift;
      w_idx_nxt   = r_idx;
      // line level follows the current state one cycle later
      w_tx_nxt    = 1'b1;
      case (r_state)
         S_IDLE: begin
            if (!w_empty) begin
               w_pop       = 1'b1;
               w_shift_nxt = r_mem[r_rptr];
               w_cnt_nxt   = w_div_m1;
               w_idx_nxt   = 3'd0;
               w_state_nxt = S_START;
            end
         end
         S_START: begin
            w_tx_nxt = 1'b0;
            if (w_bit_end) begin
               w_cnt_nxt   = w_div_m1;
               w_state_nxt = S_DATA;
            end else begin
               w_cnt_nxt = r_cnt - 16'd1;
            end
         end
         S_DATA: begin
            w_tx_nxt = r_shift[0];
            if (w_bit_end) begin
               w_cnt_nxt   = w_div_m1;
               w_shift_nxt = {1'b0, r_shift[7:1]};
               w_idx_nxt   = r_idx + 3'd1;
               if (r_idx == 3'd7) w_state_nxt = S_STOP;
            end else begin
               w_cnt_nxt = r_cnt - 16'd1;
            end
         end
         S_STOP: begin
            if (w_bit_end) begin
               if (!w_empty) begin
                  // chain straight into the next start bit, no idle gap
                  w_pop       = 1'b1;
                  w_shift_nxt = r_mem[r_rptr];
                  w_cnt_nxt   = w_div_m1;
                  w_idx_nxt   = 3'd0;
                  w_state_nxt = S_START;
               end else begin
                  w_cnt_nxt   = 16'd0;
                  w_state_nxt = S_IDLE;
               end
            end else begin
               w_cnt_nxt = r_cnt - 16'd1;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // sequencer state register
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_cnt   <= 16'd0;
         r_shift <= 8'd0;
         r_idx   <= 3'd0;
         r_tx    <= 1'b1;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_shift <= w_shift_nxt;
         r_idx   <= w_idx_nxt;
         r_tx    <= w_tx_nxt;
      end
   end

   // FIFO storage; contents need no reset since count governs validity
   always_ff @(posedge clk) begin
      if (!reset && w_push_ok) r_mem[r_wptr] <= wd[7:0];
   end

   // FIFO pointers, occupancy and sticky overflow
   always_ff @(posedge clk) begin
      if (reset) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
         r_ovf   <= 1'b0;
      end else begin
         if (w_push_ok)
            r_wptr <= (r_wptr == AW'(FIFO_DEPTH-1)) ? '0 : r_wptr + 1'b1;
         if (w_pop)
            r_rptr <= (r_rptr == AW'(FIFO_DEPTH-1)) ? '0 : r_rptr + 1'b1;
         r_count <= r_count + {{AW{1'b0}}, w_push_ok} - {{AW{1'b0}}, w_pop};
         if (w_wr_stat && wd[3]) r_ovf <= 1'b0;
         if (w_push && !w_push_ok) r_ovf <= 1'b1;
      end
   end

   // baud divisor; zero would stall the bit timer so it becomes one
   always_ff @(posedge clk) begin
      if (reset)
         r_div <= 16'(DEFAULT_DIV);
      else if (w_wr_div)
         r_div <= (wd[15:0] == 16'd0) ? 16'd1 : wd[15:0];
   end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: drives bus writes/reads and compares the sampled serial
// line against frames rebuilt from the bytes that were accepted.
module tb_uart_tx;
   localparam int DEPTH = 8;

   logic        clk = 1'b0;
   logic        reset, sel, we;
   logic [2:0]  memsize;
   logic [31:0] a, wd, rd;
   logic        tx;

   uart_tx #(.DEFAULT_DIV(16), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset), .sel(sel), .we(we), .memsize(memsize),
      .a(a), .wd(wd), .rd(rd), .tx(tx)
   );

   always #5 clk = ~clk;

   // one line sample per clock, taken 1 unit after each rising edge
   logic txs[$];
   always @(posedge clk) begin
      #1;
      txs.push_back(tx);
   end

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] status_exp(input int cnt, input bit ovf, input bit busy);
      logic [3:0] s;
      s = (cnt > 15) ? 4'hF : 4'(cnt);
      return {24'd0, s, ovf, busy, (cnt == 0), (cnt == DEPTH)};
   endfunction

   function automatic int zeros_in(input int s, input int e);
      int z = 0;
      for (int i = s; i < e && i < txs.size(); i++) if (txs[i] !== 1'b1) z++;
      return z;
   endfunction

   // bus write; idx returns the sample index taken right after the write edge
   task automatic bus_wr(input logic [1:0] r, input logic [31:0] data, output int idx);
      @(negedge clk);
      sel = 1'b1; we = 1'b1; wd = data;
      a = ($urandom() & 32'hFFFF_FFF3) | {28'd0, r, 2'b00};
      memsize = 3'($urandom());
      @(posedge clk);
      #1 sel = 1'b0; we = 1'b0;
      #1 idx = txs.size() - 1;
   endtask

   task automatic bus_rd(input logic [1:0] r, output logic [31:0] v);
      @(negedge clk);
      a = ($urandom() & 32'hFFFF_FFF3) | {28'd0, r, 2'b00};
      #1 v = rd;
   endtask

   // expected line: start 0, 8 data bits LSB first, stop 1, each div samples
   task automatic check_frames(input string tag, input int base, input int div, input logic [7:0] q[$]);
      for (int f = 0; f < q.size(); f++) begin
         logic [9:0] exp10, obs;
         int glitch;
         exp10 = {1'b1, q[f], 1'b0};
         obs = '0;
         glitch = 0;
         for (int b = 0; b < 10; b++) begin
            int st;
            st = base + f*10*div + b*div;
            if (st + div > txs.size()) begin
               glitch++;
            end else begin
               obs[b] = txs[st + div/2];
               for (int j = 0; j < div; j++) if (txs[st+j] !== obs[b]) glitch++;
            end
         end
         chk($sformatf("%s_bits%0d", tag, f), 32'(obs), 32'(exp10));
         chk($sformatf("%s_stable%0d", tag, f), glitch, 0);
      end
      chk($sformatf("%s_pre_idle", tag), {31'd0, txs[base-1]}, 32'd1);
      if (base + q.size()*10*div < txs.size())
         chk($sformatf("%s_post_idle", tag), {31'd0, txs[base + q.size()*10*div]}, 32'd1);
      else
         chk($sformatf("%s_post_missing", tag), 32'd0, 32'd1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1);
   end

   initial begin
      logic [31:0] v;
      logic [7:0]  q[$];
      logic [7:0]  d;
      int w, w0, wk, base, div, n, cnt;

      reset = 1'b1; sel = 1'b0; we = 1'b0; a = '0; wd = '0; memsize = '0;
      repeat (3) @(posedge clk);
      @(negedge clk) reset = 1'b0;

      // reset state
      chk("rst_tx", {31'd0, tx}, 32'd1);
      bus_rd(2'd1, v); chk("rst_status", v, status_exp(0, 0, 0));
      bus_rd(2'd2, v); chk("rst_div", v, 32'd16);
      bus_rd(2'd0, v); chk("txdata_rd", v, 32'd0);

      // single 0x55 frame at DIV=4, with busy window
      bus_wr(2'd2, 32'd4, w);
      bus_rd(2'd2, v); chk("div4", v, 32'd4);
      bus_wr(2'd0, 32'h55, w0);
      repeat (40) @(posedge clk);
      bus_rd(2'd1, v); chk("busy_hi", v, status_exp(0, 0, 1));
      bus_rd(2'd1, v); chk("busy_lo", v, status_exp(0, 0, 0));
      repeat (4) @(posedge clk);
      q = '{8'h55};
      check_frames("f55", w0 + 2, 4, q);

      // two back-to-back frames at DIV=2
      bus_wr(2'd2, 32'd2, w);
      bus_wr(2'd0, 32'hA1, w0);
      bus_wr(2'd0, 32'h3C, wk);
      repeat (50) @(posedge clk);
      q = '{8'hA1, 8'h3C};
      check_frames("b2b", w0 + 2, 2, q);

      // DIV=0 stored as 1
      bus_wr(2'd2, 32'd0, w);
      bus_rd(2'd2, v); chk("div0", v, 32'd1);
      bus_wr(2'd0, 32'h96, w0);
      repeat (15) @(posedge clk);
      q = '{8'h96};
      check_frames("div1", w0 + 2, 1, q);

      // random divisors and bursts
      for (int it = 0; it < 12; it++) begin
         div = $urandom_range(1, 6);
         n   = $urandom_range(1, 4);
         bus_wr(2'd2, 32'(div), w);
         q = {};
         for (int k = 0; k < n; k++) begin
            d = 8'($urandom());
            bus_wr(2'd0, {($urandom() & 32'hFFFF_FF00) | {24'd0, d}}, wk);
            if (k == 0) base = wk + 2;
            q.push_back(d);
         end
         repeat (10*div*n + 6) @(posedge clk);
         check_frames($sformatf("rnd%0d", it), base, div, q);
         bus_rd(2'd1, v); chk($sformatf("rnd%0d_status", it), v, status_exp(0, 0, 0));
      end

      // stall with a long start bit, overfill the FIFO
      bus_wr(2'd2, 32'd100, w);
      bus_wr(2'd0, 32'hFF, w0);
      q = {}; cnt = 0;
      begin
         bit movf = 0;
         for (int k = 0; k < 10; k++) begin
            d = 8'($urandom());
            bus_wr(2'd0, {24'd0, d}, wk);
            if (cnt < DEPTH) begin q.push_back(d); cnt++; end
            else movf = 1;
         end
         bus_rd(2'd1, v); chk("ovf_status", v, status_exp(cnt, movf, 1));
      end
      bus_wr(2'd1, 32'h8, w);
      bus_rd(2'd1, v); chk("ovf_clr", v, status_exp(cnt, 0, 1));
      bus_wr(2'd2, 32'd2, w);
      // push on the edge the first frame ends: full FIFO pops and pushes together
      for (int g = 0; g < 1000 && (txs.size() - 1 - w0) < 118; g++) begin
         @(posedge clk); #2;
      end
      d = 8'($urandom());
      bus_wr(2'd0, {24'd0, d}, wk);
      q.push_back(d);
      bus_rd(2'd1, v); chk("full_pushpop", v, status_exp(cnt, 0, 1));
      repeat (240) @(posedge clk);
      chk("stall_start", 32'(zeros_in(w0 + 2, w0 + 102)), 32'd100);
      chk("stall_tail", 32'(zeros_in(w0 + 102, w0 + 120)), 32'd0);
      check_frames("ovf", w0 + 120, 2, q);
      chk("no_extra", 32'(zeros_in(w0 + 120 + 10*2*q.size(), txs.size())), 32'd0);
      bus_rd(2'd1, v); chk("drained", v, status_exp(0, 0, 0));

      // reset during data bit 3 with two bytes queued, racing a bus write
      bus_wr(2'd2, 32'd8, w);
      bus_wr(2'd0, 32'h00, w0);
      bus_wr(2'd0, 32'h3A, wk);
      bus_wr(2'd0, 32'hC5, wk);
      for (int g = 0; g < 1000 && (txs.size() - 1 - w0) < 35; g++) begin
         @(posedge clk); #2;
      end
      @(negedge clk);
      reset = 1'b1; sel = 1'b1; we = 1'b1; a = 32'h0; wd = 32'h5A;
      @(posedge clk);
      #1 reset = 1'b0; sel = 1'b0; we = 1'b0;
      #2;
      chk("pre_rst_bit3", {31'd0, txs[w0 + 35]}, 32'd0);
      chk("rst_tx_next", {31'd0, txs[w0 + 36]}, 32'd1);
      bus_rd(2'd1, v); chk("rst_mid_status", v, status_exp(0, 0, 0));
      bus_rd(2'd2, v); chk("rst_mid_div", v, 32'd16);
      repeat (300) @(posedge clk);
      chk("rst_no_frames", 32'(zeros_in(w0 + 36, txs.size())), 32'd0);

      // reserved register
      bus_rd(2'd3, v); chk("rsvd_rd", v, 32'd0);
      bus_wr(2'd3, 32'hFFFF_FFFF, w);
      bus_rd(2'd1, v); chk("rsvd_status", v, status_exp(0, 0, 0));
      bus_rd(2'd2, v); chk("rsvd_div", v, 32'd16);
      repeat (20) @(posedge clk);
      chk("rsvd_idle", 32'(zeros_in(w, txs.size())), 32'd0);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end
endmodule
